alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor of the EX-stage single-cycle ALU.
- Sits in the EX stage and serves as the execute unit for the pipeline.
- Extends the operation set with XOR, set-less-than and shifts, plus an iterative multi-cycle multiply.
- Uses valid/ready on both sides so the hazard unit can stall on `busy`.
- All outputs are registered.

Parameters:
- WIDTH, 32: operand/result width; power of two, >= 8.
- SHW, $clog2(WIDTH): shift-amount width; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operation offered
- in_ready  output  1  block can accept an operation this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- control  input  4  operation select
- out_valid  output  1  result/zero valid
- out_ready  input  1  consumer takes result this cycle
- result  output  WIDTH  registered result
- zero  output  1  (result == 0), combinational from registered result
- busy  output  1  high in MUL state

Behaviour:
- Encodings (existing codes keep their meaning):
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 XOR
  - 0111 SLT (signed, result 0 or 1), 1000 SLTU (unsigned)
  - 1001 SLL, 1010 SRL, 1011 SRA; shift amount is B[SHW-1:0], upper bits of B ignored
  - 1100 MUL: low WIDTH bits of A*B; signedness is irrelevant for the low half
  - all other codes: result 0, latency 1
- Arithmetic rules: ADD/SUB wrap modulo 2^WIDTH; no flags other than zero.
- FSM states: IDLE, MUL, DONE.
- Transfer: an operation is accepted on a rising edge where in_valid && in_ready.
- Output handshake: the result is consumed on an edge where out_valid && out_ready.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Single-cycle ops: result is written at the accept edge; state goes to DONE. out_valid is high in the cycle after acceptance (latency 1).
- MUL:
  - At the accept edge, load multiplicand, multiplier and accumulator = 0; iteration count = 0; state goes to MUL.
  - Each edge in MUL processes one multiplier bit (shift-add).
  - After WIDTH iterations: result = accumulator, state goes to DONE.
  - out_valid rises exactly WIDTH+1 cycles after the accept edge. Latency is fixed, independent of operand values; B=0 still takes the full latency.
- DONE:
  - out_valid=1. result and zero are held stable until consumed.
  - Consumed with no new op: go to IDLE, out_valid=0, result holds its last value.
  - Consumed with a simultaneous new op: accept it on the same edge. Single-cycle ops then sustain 1 op/cycle.
  - out_ready=0: hold; in_ready=0.
- During MUL: in_ready=0, out_valid=0, busy=1; in_valid is ignored.
- Inputs are sampled only at the accept edge. Later changes to A, B or control do not affect an op in flight.
- Reset, asynchronous at any time including mid-MUL: state IDLE, out_valid=0, busy=0, result=0 (so zero=1), iteration counter=0. The in-flight op is discarded. in_ready=1 while rst is low again in IDLE.
- No X on any output after reset.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: MUL (1100) is implemented as above; busy can assert.
- Undefined:
  - No multiplier datapath or iteration counter is built.
  - 1100 behaves as an undefined code: result 0, latency 1.
  - The MUL state is unreachable; busy is tied 0.

Test Plan:
- Reset then single ops, WIDTH=32:
  - ADD A=5, B=7 -> out_valid next cycle, result=12, zero=0.
  - SUB A=9, B=9 -> result=0, zero=1.
- Signed/unsigned compare and wrap, A=32'hFFFFFFFF, B=1:
  - SLT -> 1; SLTU -> 0.
  - ADD -> result=0, zero=1.
- Shifts:
  - SRA A=32'h80000000, B=32'h00000024 (amount 4) -> 32'hF8000000.
  - SRL same operands -> 32'h08000000.
  - SLL A=1, B=31 -> 32'h80000000.
- MUL (macro defined):
  - A=32'h00010001, B=32'h00010001 -> result 32'h00020001 exactly 33 cycles after accept.
  - busy=1 and in_ready=0 throughout; in_valid pulses meanwhile are not accepted.
- Backpressure/back-to-back:
  - Hold out_ready=0 two cycles after ADD 1+1 -> result stays 2, in_ready=0.
  - Then out_ready=1 with in_valid XOR 6^3 on the same edge -> next cycle result=5, out_valid=1.
- Reset mid-MUL: assert rst 10 cycles into a MUL -> out_valid=0, busy=0, result=0, zero=1 immediately; after release, ADD 2+2 returns 4 with latency 1.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked EX-stage ALU with registered result; single-cycle ops and an optional
// iterative shift-add multiplier built only when ALU_SEQ_MUL_EN is defined.
module alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpXor  = 4'b0011;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSlt  = 4'b0111;
    localparam logic [3:0] OpSltu = 4'b1000;
    localparam logic [3:0] OpSll  = 4'b1001;
    localparam logic [3:0] OpSrl  = 4'b1010;
    localparam logic [3:0] OpSra  = 4'b1011;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   shamt;
    logic             accept;

    assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign zero      = (result_q == '0);
    assign shamt     = B[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (control)
            OpAnd:   alu_res = A & B;
            OpOr:    alu_res = A | B;
            OpAdd:   alu_res = A + B;
            OpXor:   alu_res = A ^ B;
            OpSub:   alu_res = A - B;
            OpSlt:   alu_res = WIDTH'($signed(A) < $signed(B));
            OpSltu:  alu_res = WIDTH'(A < B);
            OpSll:   alu_res = A << shamt;
            OpSrl:   alu_res = A >> shamt;
            OpSra:   alu_res = $unsigned($signed(A) >>> shamt);
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    localparam logic [1:0] StMul = 2'd1;
    localparam logic [3:0] OpMul = 4'b1100;

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] acc_sum;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             last_iter;

    // One multiplier bit per cycle, LSB first; multiplicand shifts up to match.
    assign acc_sum   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign last_iter = (cnt_q == SHW'(WIDTH - 1));
    assign busy      = (state_q == StMul);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    assign busy = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
`ifdef ALU_SEQ_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
`endif
        if (accept) begin
`ifdef ALU_SEQ_MUL_EN
            if (control == OpMul) begin
                mcand_d  = A;
                mplier_d = B;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = StMul;
            end else
`endif
            begin
                result_d = alu_res;
                state_d  = StDone;
            end
        end else if ((state_q == StDone) && out_ready) begin
            state_d = StIdle;
        end
`ifdef ALU_SEQ_MUL_EN
        else if (state_q == StMul) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (last_iter) begin
                result_d = acc_sum;
                cnt_d    = '0;
                state_d  = StDone;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed plus randomized bench for alu_seq, checked against a plain-arithmetic model.
module tb_alu_seq;

    localparam int unsigned W = 32;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic [3:0]    control = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  result;
    logic          zero;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .control   (control),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'h0:    return a & b;
            4'h1:    return a | b;
            4'h2:    return a + b;
            4'h3:    return a ^ b;
            4'h6:    return a - b;
            4'h7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h8:    return (a < b) ? 32'd1 : 32'd0;
            4'h9:    return a << sh;
            4'hA:    return a >> sh;
            4'hB:    return (a >> sh) | ((a >= 32'h8000_0000) ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            4'hC:    return MulEn ? a * b : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] op);
        return (MulEn && op == 4'hC) ? W + 1 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op from IDLE, scramble inputs after accept, wait (bounded), check, drain.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] exp;
        int          lat;
        exp = model(op, a, b);
        @(negedge clk);
        in_valid  = 1'b1;
        control   = op;
        A         = a;
        B         = b;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        A        = $urandom;
        B        = $urandom;
        control  = 4'($urandom);
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, model_lat(op));
        check({tag, " result"}, result, exp);
        check({tag, " zero"}, 32'(zero), 32'(exp == 32'h0));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " drained"}, 32'(out_valid), 32'h0);
        check({tag, " held"}, result, exp);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          lat;

        repeat (2) @(negedge clk);
        check("rst out_valid", 32'(out_valid), 32'h0);
        check("rst busy", 32'(busy), 32'h0);
        check("rst result", result, 32'h0);
        check("rst zero", 32'(zero), 32'h1);
        rst = 1'b0;
        #1;
        check("rst in_ready", 32'(in_ready), 32'h1);

        run_op("add 5+7", 4'h2, 32'd5, 32'd7);
        run_op("sub 9-9", 4'h6, 32'd9, 32'd9);
        run_op("slt -1<1", 4'h7, 32'hFFFF_FFFF, 32'd1);
        run_op("sltu max<1", 4'h8, 32'hFFFF_FFFF, 32'd1);
        run_op("add wrap", 4'h2, 32'hFFFF_FFFF, 32'd1);
        run_op("sra", 4'hB, 32'h8000_0000, 32'h0000_0024);
        run_op("srl", 4'hA, 32'h8000_0000, 32'h0000_0024);
        run_op("sll", 4'h9, 32'd1, 32'd31);
        run_op("undef d", 4'hD, 32'h1234_5678, 32'h1);
        run_op("mul", 4'hC, 32'h0001_0001, 32'h0001_0001);

`ifdef ALU_SEQ_MUL_EN
        // Stall window: busy high, in_ready low, stray in_valid pulses ignored.
        @(negedge clk);
        in_valid = 1'b1;
        control  = 4'hC;
        A        = 32'h0001_0001;
        B        = 32'h0001_0001;
        @(negedge clk);
        control = 4'h2;
        A       = 32'd2;
        B       = 32'd3;
        lat     = 1;
        while (!out_valid && lat < 100) begin
            check("mul busy", 32'(busy), 32'h1);
            check("mul in_ready", 32'(in_ready), 32'h0);
            in_valid = lat[0];
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check("mul stall latency", lat, W + 1);
        check("mul stall result", result, 32'h0002_0001);
        check("mul done busy", 32'(busy), 32'h0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("mul stall drained", 32'(out_valid), 32'h0);
        run_op("mul b=0", 4'hC, 32'hDEAD_BEEF, 32'h0);
`endif

        // Backpressure then same-edge consume+accept, sustaining 1 op/cycle.
        @(negedge clk);
        in_valid = 1'b1;
        control  = 4'h2;
        A        = 32'd1;
        B        = 32'd1;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp valid", 32'(out_valid), 32'h1);
        check("bp result", result, 32'd2);
        repeat (2) begin
            @(negedge clk);
            check("bp hold result", result, 32'd2);
            check("bp hold valid", 32'(out_valid), 32'h1);
            check("bp hold in_ready", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        control   = 4'h3;
        A         = 32'd6;
        B         = 32'd3;
        #1;
        check("b2b in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        check("b2b xor valid", 32'(out_valid), 32'h1);
        check("b2b xor result", result, 32'd5);
        control = 4'h1;
        A       = 32'd8;
        B       = 32'd1;
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b or valid", 32'(out_valid), 32'h1);
        check("b2b or result", result, 32'd9);
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b drained", 32'(out_valid), 32'h0);

        // Asynchronous reset part-way through an op.
        run_op("pre-rst add", 4'h2, 32'd2, 32'd3);
        @(negedge clk);
        in_valid = 1'b1;
`ifdef ALU_SEQ_MUL_EN
        control = 4'hC;
`else
        control = 4'h2;
`endif
        A = 32'd3;
        B = 32'd5;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst out_valid", 32'(out_valid), 32'h0);
        check("midrst busy", 32'(busy), 32'h0);
        check("midrst result", result, 32'h0);
        check("midrst zero", 32'(zero), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("postrst in_ready", 32'(in_ready), 32'h1);
        run_op("postrst add", 4'h2, 32'd2, 32'd2);

        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(15));
            ra  = $urandom;
            rb  = ($urandom_range(3) == 0) ? ra : $urandom;
            run_op($sformatf("rand%0d op%h", i, rop), rop, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

endmodule
